irq_enable_pending: RTL and testbench
=====================================

# irq_enable_pending

Parametrised machine-interrupt enable/pending unit for the Hunter_RV32 CSR file: it holds the MIE enable register and the MIP pending register for NUM_IRQ sources. It performs per-source edge or level capture, supports CSR write/set/clear updates, and presents one prioritised interrupt request to the trap logic under a req/ack handshake. It generalises the fixed 4-bit enable register to N channels and adds pending tracking and request arbitration.

## Interface
- NUM_IRQ, 4: number of interrupt sources (1..32)
- ID_W, max(1, clog2(NUM_IRQ)): width of irq_id
- RST_EN, all ones: reset value of the enable register
- EDGE_MASK, all ones: per-source mode; 1 = rising-edge, 0 = level
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- csr_we  in  1  CSR access strobe
- csr_op  in  2  00 none, 01 write, 10 set bits, 11 clear bits
- csr_sel  in  1  0 = enable register, 1 = pending register
- csr_wdata  in  NUM_IRQ  write/set/clear operand
- csr_rdata  out  NUM_IRQ  selected register, current (pre-write) value, combinational
- irq_src  in  NUM_IRQ  raw interrupt lines, synchronous to clk
- gie  in  1  global interrupt enable (mstatus.MIE)
- irq_req  out  1  interrupt request, registered
- irq_id  out  ID_W  index of requested source, stable while irq_req=1
- irq_ack  in  1  trap logic accepts the current request

## Operation
- Reset values: enable=RST_EN, pending=0, src_q=0, state IDLE, irq_req=0, irq_id=0.
- Edge sources: src_q registers irq_src each cycle. A rising edge (irq_src & ~src_q) sets pending. A source already high at reset release is a rising edge.
- Level sources: pending[i] <= irq_src[i] every cycle. CSR writes, set/clear and ack do not modify level bits.
- Enable register: write replaces the value, set ORs, clear ANDs-NOT, each with csr_wdata. csr_op=00 or csr_we=0 leaves it unchanged.
- Pending register: the same ops, applied only to edge bits.
- Priority when several pending-bit updates hit the same cycle: hardware edge set beats software clear and beats ack clear. Software set/write beats ack clear.
- active = pending & enable. Winner = lowest index of active (sub-module irq_prio_enc).
- FSM IDLE:
  - If gie and |active, go to REQ. Latch irq_id = winner; irq_req=1.
- FSM REQ:
  - irq_id is frozen, even if a lower-index source becomes active.
  - On irq_ack: clear pending[irq_id] if it is an edge source, go to GAP, irq_req=0.
  - Else if active[irq_id]=0 or gie=0: withdraw, go to IDLE, irq_req=0.
- FSM GAP: one cycle, irq_req=0, then IDLE. This prevents a double-fire on a level source that is still held high.
- irq_ack outside REQ is ignored.

## Timing
- Edge source rising before clock edge k: pending visible after k. irq_req high after k+1, so latency is 2 cycles.
- The ack cycle is the last cycle with irq_req=1. After that, irq_req is low for at least 2 cycles (GAP, IDLE) before the next request.
- CSR updates take effect at the next clock edge. csr_rdata reflects them one cycle after the write.
- Withdrawal takes effect at the edge after the cause appears.
- Asserting rst mid-request drops irq_req immediately, asynchronously, and clears pending.

## Structure
- Package irq_pkg: csr_op encodings (OP_NONE, OP_WRITE, OP_SET, OP_CLR), csr_sel encodings, FSM state enum (IDLE, REQ, GAP).
- Sub-module irq_prio_enc: combinational, NUM_IRQ-wide lowest-index encoder. Outputs any and idx.
- Top level: registers, edge detect, CSR update muxing and FSM.

## Test plan
All scenarios use NUM_IRQ=4, ID_W=2 and default parameters.
- Reset: release rst -> csr_rdata(sel 0)=4'hF, csr_rdata(sel 1)=4'h0, irq_req=0.
- CSR ops on enable: write 4'hA, then set 4'h1, then clear 4'h8 -> reads 4'hA, 4'hB, 4'h3.
- Edge capture: gie=1, pulse irq_src[2] for one cycle -> irq_req=1 with irq_id=2 two cycles later. irq_ack -> pending reads 4'h0, irq_req low for 2 cycles.
- Priority and freeze: src[3] raises, then src[1] raises while in REQ -> irq_id stays 3 until ack. Next request has irq_id=1.
- Withdraw: in REQ for id 2, csr clear of enable bit 2 -> irq_req=0 next cycle, pending[2] still 1.
- Collisions: edge on src[0] in the same cycle as a csr clear of pending bit 0 -> pending[0]=1. Level mode (EDGE_MASK=4'h0): hold src[1] high, ack -> irq_req re-asserts after GAP and IDLE.

Source files
------------

// File: rtl/irq_enable_pending_pkg.sv
// Shared encodings for the machine-interrupt enable/pending unit:
// CSR operation codes, register select values and the request FSM states.
package irq_pkg;

  localparam logic [1:0] OP_NONE  = 2'b00;
  localparam logic [1:0] OP_WRITE = 2'b01;
  localparam logic [1:0] OP_SET   = 2'b10;
  localparam logic [1:0] OP_CLR   = 2'b11;

  localparam logic SEL_ENABLE  = 1'b0;
  localparam logic SEL_PENDING = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/irq_enable_pending_prio_enc.sv
// Lowest-index-wins priority encoder over the active interrupt vector.
// Purely combinational; idx is zero when nothing is active.
module irq_prio_enc #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    req,
  output logic            any,
  output logic [ID_W-1:0] idx
);

  always_comb begin
    any = |req;
    idx = '0;
    // Scan downwards so the lowest set index is the last one assigned.
    for (int i = N - 1; i >= 0; i--) begin
      if (req[i]) begin
        idx = ID_W'(i);
      end
    end
  end

endmodule

// File: rtl/irq_enable_pending.sv
// MIE/MIP register pair for NUM_IRQ machine interrupt sources with edge/level
// capture, CSR write/set/clear access and a single prioritised req/ack output.
module irq_enable_pending
  import irq_pkg::*;
#(
  parameter int                 NUM_IRQ   = 4,
  parameter int                 ID_W      = (NUM_IRQ > 1) ? $clog2(NUM_IRQ) : 1,
  parameter logic [NUM_IRQ-1:0] RST_EN    = '1,
  parameter logic [NUM_IRQ-1:0] EDGE_MASK = '1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               csr_we,
  input  logic [1:0]         csr_op,
  input  logic               csr_sel,
  input  logic [NUM_IRQ-1:0] csr_wdata,
  output logic [NUM_IRQ-1:0] csr_rdata,
  input  logic [NUM_IRQ-1:0] irq_src,
  input  logic               gie,
  output logic               irq_req,
  output logic [ID_W-1:0]    irq_id,
  input  logic               irq_ack
);

  logic [NUM_IRQ-1:0] enable_reg,  enable_next;
  logic [NUM_IRQ-1:0] pending_reg, pending_next;
  logic [NUM_IRQ-1:0] src_q_reg;
  state_t             state_reg,   state_next;
  logic [ID_W-1:0]    id_reg,      id_next;

  logic [NUM_IRQ-1:0] active;
  logic [NUM_IRQ-1:0] ack_mask;
  logic [NUM_IRQ-1:0] pend_after_ack;
  logic [NUM_IRQ-1:0] pend_sw;
  logic [NUM_IRQ-1:0] edge_set;
  logic               ack_fire;
  logic               win_any;
  logic [ID_W-1:0]    win_idx;

  assign active   = pending_reg & enable_reg;
  assign ack_fire = (state_reg == REQ) && irq_ack;
  assign edge_set = irq_src & ~src_q_reg;

  // One-hot decode of the acknowledged source.
  for (genvar gi = 0; gi < NUM_IRQ; gi++) begin : g_ack
    assign ack_mask[gi] = ack_fire && (id_reg == ID_W'(gi));
  end

  irq_prio_enc #(
    .N    (NUM_IRQ),
    .ID_W (ID_W)
  ) u_prio (
    .req (active),
    .any (win_any),
    .idx (win_idx)
  );

  always_comb begin
    enable_next = enable_reg;
    if (csr_we && (csr_sel == SEL_ENABLE)) begin
      case (csr_op)
        OP_WRITE: enable_next = csr_wdata;
        OP_SET:   enable_next = enable_reg | csr_wdata;
        OP_CLR:   enable_next = enable_reg & ~csr_wdata;
        default:  enable_next = enable_reg;
      endcase
    end
  end

  // Layering gives the collision priority: ack clear first, software op on
  // top of that, hardware edge set last so it always wins.
  always_comb begin
    pend_after_ack = pending_reg & ~ack_mask;
    pend_sw        = pend_after_ack;
    if (csr_we && (csr_sel == SEL_PENDING)) begin
      case (csr_op)
        OP_WRITE: pend_sw = csr_wdata;
        OP_SET:   pend_sw = pend_after_ack | csr_wdata;
        OP_CLR:   pend_sw = pend_after_ack & ~csr_wdata;
        default:  pend_sw = pend_after_ack;
      endcase
    end
    pending_next = ((pend_sw | edge_set) & EDGE_MASK) | (irq_src & ~EDGE_MASK);
  end

  always_comb begin
    state_next = state_reg;
    id_next    = id_reg;
    case (state_reg)
      IDLE: begin
        if (gie && win_any) begin
          state_next = REQ;
          id_next    = win_idx;
        end
      end
      REQ: begin
        // id stays frozen here; only ack or withdrawal can leave.
        if (irq_ack) begin
          state_next = GAP;
        end else if (!active[id_reg] || !gie) begin
          state_next = IDLE;
        end
      end
      GAP:     state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      enable_reg  <= RST_EN;
      pending_reg <= '0;
      src_q_reg   <= '0;
      state_reg   <= IDLE;
      id_reg      <= '0;
    end else begin
      enable_reg  <= enable_next;
      pending_reg <= pending_next;
      src_q_reg   <= irq_src;
      state_reg   <= state_next;
      id_reg      <= id_next;
    end
  end

  assign csr_rdata = (csr_sel == SEL_PENDING) ? pending_reg : enable_reg;
  assign irq_req   = (state_reg == REQ);
  assign irq_id    = id_reg;

endmodule

// File: tb/tb_irq_enable_pending.sv
// Bench for irq_enable_pending: an all-edge and an all-level instance share
// stimulus and are checked by directed scenarios and a randomized model run.
module tb_irq_enable_pending;

  logic       clk;
  logic       rst;
  logic       csr_we;
  logic [1:0] csr_op;
  logic       csr_sel;
  logic [3:0] csr_wdata;
  logic [3:0] irq_src;
  logic       gie;
  logic       ack_e, ack_l;
  logic [3:0] rdata_e, rdata_l;
  logic       req_e, req_l;
  logic [1:0] id_e, id_l;

  int errors = 0;
  int checks = 0;

  irq_enable_pending #(.NUM_IRQ(4), .ID_W(2)) dut_e (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata), .csr_rdata(rdata_e), .irq_src(irq_src), .gie(gie),
    .irq_req(req_e), .irq_id(id_e), .irq_ack(ack_e)
  );

  irq_enable_pending #(.NUM_IRQ(4), .ID_W(2), .EDGE_MASK(4'h0)) dut_l (
    .clk(clk), .rst(rst), .csr_we(csr_we), .csr_op(csr_op), .csr_sel(csr_sel),
    .csr_wdata(csr_wdata), .csr_rdata(rdata_l), .irq_src(irq_src), .gie(gie),
    .irq_req(req_l), .irq_id(id_l), .irq_ack(ack_l)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: index 0 = all-edge instance, 1 = all-level instance.
  // m_state: 0 idle, 1 requesting, 2 gap.
  logic [3:0] m_en[2];
  logic [3:0] m_pend[2];
  logic [3:0] m_srcq[2];
  int         m_state[2];
  int         m_id[2];

  always @(posedge clk or posedge rst) begin
    logic [3:0] act, newp, newe;
    int         win;
    logic       ackv;
    if (rst) begin
      for (int m = 0; m < 2; m++) begin
        m_en[m] <= 4'hF; m_pend[m] <= 4'h0; m_srcq[m] <= 4'h0;
        m_state[m] <= 0; m_id[m] <= 0;
      end
    end else begin
      for (int m = 0; m < 2; m++) begin
        act  = m_pend[m] & m_en[m];
        win  = -1;
        for (int i = 0; i < 4; i++) if (act[i] && win < 0) win = i;
        ackv = (m == 0) ? ack_e : ack_l;
        for (int i = 0; i < 4; i++) begin
          if (m == 0) begin
            newp[i] = m_pend[m][i];
            if (m_state[m] == 1 && ackv && m_id[m] == i) newp[i] = 1'b0;
            if (csr_we && csr_sel) begin
              if (csr_op == 2'b01) newp[i] = csr_wdata[i];
              if (csr_op == 2'b10 && csr_wdata[i]) newp[i] = 1'b1;
              if (csr_op == 2'b11 && csr_wdata[i]) newp[i] = 1'b0;
            end
            if (irq_src[i] && !m_srcq[m][i]) newp[i] = 1'b1;
          end else begin
            newp[i] = irq_src[i];
          end
          newe[i] = m_en[m][i];
          if (csr_we && !csr_sel) begin
            if (csr_op == 2'b01) newe[i] = csr_wdata[i];
            if (csr_op == 2'b10 && csr_wdata[i]) newe[i] = 1'b1;
            if (csr_op == 2'b11 && csr_wdata[i]) newe[i] = 1'b0;
          end
        end
        if (m_state[m] == 0) begin
          if (gie && win >= 0) begin m_state[m] <= 1; m_id[m] <= win; end
        end else if (m_state[m] == 1) begin
          if (ackv) m_state[m] <= 2;
          else if (!act[m_id[m]] || !gie) m_state[m] <= 0;
        end else begin
          m_state[m] <= 0;
        end
        m_pend[m] <= newp;
        m_en[m]   <= newe;
        m_srcq[m] <= irq_src;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; csr_we = 0; csr_op = 2'b00; csr_sel = 0; csr_wdata = 0;
    irq_src = 0; gie = 0; ack_e = 0; ack_l = 0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    csr_sel = 1'b0; #1;
    checks++; if (rdata_e !== 4'hF) begin errors++; $display("FAIL reset_enable_e got=%h want=F", rdata_e); end
    checks++; if (rdata_l !== 4'hF) begin errors++; $display("FAIL reset_enable_l got=%h want=F", rdata_l); end
    csr_sel = 1'b1; #1;
    checks++; if (rdata_e !== 4'h0) begin errors++; $display("FAIL reset_pending_e got=%h want=0", rdata_e); end
    checks++; if (rdata_l !== 4'h0) begin errors++; $display("FAIL reset_pending_l got=%h want=0", rdata_l); end
    checks++; if (req_e !== 1'b0 || req_l !== 1'b0) begin errors++; $display("FAIL reset_req got=%b%b want=00", req_e, req_l); end
    checks++; if (id_e !== 2'd0) begin errors++; $display("FAIL reset_id got=%0d want=0", id_e); end
    $display("test_reset done");
  endtask

  task automatic test_enable_ops();
    logic [1:0] ops[3]  = '{2'b01, 2'b10, 2'b11};
    logic [3:0] wds[3]  = '{4'hA, 4'h1, 4'h8};
    logic [3:0] exps[3] = '{4'hA, 4'hB, 4'h3};
    gie = 0;
    for (int k = 0; k < 3; k++) begin
      csr_we = 1; csr_sel = 0; csr_op = ops[k]; csr_wdata = wds[k];
      step();
      csr_we = 0; #1;
      checks++; if (rdata_e !== exps[k]) begin errors++; $display("FAIL enable_op%0d_e got=%h want=%h", k, rdata_e, exps[k]); end
      checks++; if (rdata_l !== exps[k]) begin errors++; $display("FAIL enable_op%0d_l got=%h want=%h", k, rdata_l, exps[k]); end
    end
    csr_we = 1; csr_op = 2'b01; csr_wdata = 4'hF; step(); csr_we = 0;
    $display("test_enable_ops done");
  endtask

  task automatic test_edge_capture();
    gie = 1; ack_e = 0; irq_src = 4'b0100;
    step();
    irq_src = 4'b0000;
    checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL edge_latency1 got=%b want=0", req_e); end
    step();
    checks++; if (req_e !== 1'b1 || id_e !== 2'd2) begin errors++; $display("FAIL edge_req got=%b/%0d want=1/2", req_e, id_e); end
    ack_e = 1; step(); ack_e = 0;
    csr_sel = 1; #1;
    checks++; if (rdata_e !== 4'h0) begin errors++; $display("FAIL edge_ack_pending got=%h want=0", rdata_e); end
    checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL edge_gap got=%b want=0", req_e); end
    step();
    checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL edge_idle got=%b want=0", req_e); end
    $display("test_edge_capture done");
  endtask

  task automatic test_priority_freeze();
    irq_src = 4'b1000; step(); step();
    checks++; if (req_e !== 1'b1 || id_e !== 2'd3) begin errors++; $display("FAIL prio_first got=%b/%0d want=1/3", req_e, id_e); end
    irq_src = 4'b1010;
    for (int k = 0; k < 3; k++) begin
      step();
      checks++; if (req_e !== 1'b1 || id_e !== 2'd3) begin errors++; $display("FAIL prio_freeze%0d got=%b/%0d want=1/3", k, req_e, id_e); end
    end
    ack_e = 1; step(); ack_e = 0;
    for (int k = 0; k < 8 && !req_e; k++) step();
    checks++; if (req_e !== 1'b1 || id_e !== 2'd1) begin errors++; $display("FAIL prio_next got=%b/%0d want=1/1", req_e, id_e); end
    ack_e = 1; step(); ack_e = 0;
    irq_src = 4'b0000; step(); step(); step();
    $display("test_priority_freeze done");
  endtask

  task automatic test_withdraw();
    irq_src = 4'b0100; step(); irq_src = 4'b0000; step();
    checks++; if (req_e !== 1'b1 || id_e !== 2'd2) begin errors++; $display("FAIL withdraw_req got=%b/%0d want=1/2", req_e, id_e); end
    csr_we = 1; csr_sel = 0; csr_op = 2'b11; csr_wdata = 4'b0100;
    step(); csr_we = 0; step();
    checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL withdraw_drop got=%b want=0", req_e); end
    csr_sel = 1; #1;
    checks++; if (rdata_e[2] !== 1'b1) begin errors++; $display("FAIL withdraw_pending got=%b want=1", rdata_e[2]); end
    csr_we = 1; csr_sel = 1; csr_op = 2'b11; csr_wdata = 4'b0100; step();
    csr_sel = 0; csr_op = 2'b01; csr_wdata = 4'hF; step(); csr_we = 0;
    $display("test_withdraw done");
  endtask

  task automatic test_collision();
    gie = 0; irq_src = 4'b0001;
    csr_we = 1; csr_sel = 1; csr_op = 2'b11; csr_wdata = 4'b0001;
    step(); csr_we = 0; #1;
    checks++; if (rdata_e[0] !== 1'b1) begin errors++; $display("FAIL collide_edge_vs_clr got=%b want=1", rdata_e[0]); end
    irq_src = 4'b0000; csr_we = 1; step(); csr_we = 0;
    gie = 1; irq_src = 4'b0010;
    for (int k = 0; k < 6 && !req_l; k++) step();
    checks++; if (req_l !== 1'b1 || id_l !== 2'd1) begin errors++; $display("FAIL level_req got=%b/%0d want=1/1", req_l, id_l); end
    ack_l = 1; step(); ack_l = 0;
    checks++; if (req_l !== 1'b0) begin errors++; $display("FAIL level_gap got=%b want=0", req_l); end
    step();
    checks++; if (req_l !== 1'b0) begin errors++; $display("FAIL level_idle got=%b want=0", req_l); end
    step();
    checks++; if (req_l !== 1'b1 || id_l !== 2'd1) begin errors++; $display("FAIL level_refire got=%b/%0d want=1/1", req_l, id_l); end
    irq_src = 4'b0000; gie = 0; ack_e = 1; step(); ack_e = 0;
    step(); step();
    $display("test_collision done");
  endtask

  task automatic test_async_reset();
    gie = 1; irq_src = 4'b0100; step(); irq_src = 4'b0000; step();
    checks++; if (req_e !== 1'b1) begin errors++; $display("FAIL arst_pre got=%b want=1", req_e); end
    #2 rst = 1'b1; csr_sel = 1; #1;
    checks++; if (req_e !== 1'b0) begin errors++; $display("FAIL arst_req got=%b want=0", req_e); end
    checks++; if (rdata_e !== 4'h0) begin errors++; $display("FAIL arst_pending got=%h want=0", rdata_e); end
    step(); rst = 1'b0;
    csr_sel = 0; #1;
    checks++; if (rdata_e !== 4'hF) begin errors++; $display("FAIL arst_enable got=%h want=F", rdata_e); end
    $display("test_async_reset done");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      csr_we    = ($urandom_range(0, 3) == 0);
      csr_op    = 2'($urandom);
      csr_sel   = 1'($urandom);
      csr_wdata = 4'($urandom);
      if ($urandom_range(0, 2) == 0) irq_src = irq_src ^ 4'($urandom);
      gie   = ($urandom_range(0, 7) != 0);
      ack_e = ($urandom_range(0, 2) == 0);
      ack_l = ($urandom_range(0, 2) == 0);
      step();
      checks++; if (req_e !== (m_state[0] == 1)) begin errors++; $display("FAIL rnd_req_e cyc=%0d got=%b want=%b", n, req_e, m_state[0] == 1); end
      checks++; if (req_l !== (m_state[1] == 1)) begin errors++; $display("FAIL rnd_req_l cyc=%0d got=%b want=%b", n, req_l, m_state[1] == 1); end
      if (m_state[0] == 1) begin
        checks++; if (id_e !== 2'(m_id[0])) begin errors++; $display("FAIL rnd_id_e cyc=%0d got=%0d want=%0d", n, id_e, m_id[0]); end
      end
      if (m_state[1] == 1) begin
        checks++; if (id_l !== 2'(m_id[1])) begin errors++; $display("FAIL rnd_id_l cyc=%0d got=%0d want=%0d", n, id_l, m_id[1]); end
      end
      checks++; if (rdata_e !== (csr_sel ? m_pend[0] : m_en[0])) begin errors++; $display("FAIL rnd_rdata_e cyc=%0d sel=%b got=%h want=%h", n, csr_sel, rdata_e, csr_sel ? m_pend[0] : m_en[0]); end
      checks++; if (rdata_l !== (csr_sel ? m_pend[1] : m_en[1])) begin errors++; $display("FAIL rnd_rdata_l cyc=%0d sel=%b got=%h want=%h", n, csr_sel, rdata_l, csr_sel ? m_pend[1] : m_en[1]); end
    end
    csr_we = 0; ack_e = 0; ack_l = 0;
    $display("test_random done");
  endtask

  initial begin
    test_reset();
    test_enable_ops();
    test_edge_capture();
    test_priority_freeze();
    test_withdraw();
    test_collision();
    test_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
